// File: rtl/mac_ctrl_if.sv
// rtl/mac_ctrl_if.sv - operand stream, result stream and multiplier port bundle for mac_ctrl
interface mac_ctrl_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic             timeout_err;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_start;
  logic [16:0]      mul_o;
  logic             mul_fin;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready, mul_o, mul_fin,
    output in_ready, out_valid, acc_out, ovf, timeout_err, mul_a, mul_b, mul_start
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready, mul_o, mul_fin,
    input  in_ready, out_valid, acc_out, ovf, timeout_err, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - operand FIFO feeding a shift-add multiplier, dot-product accumulator
// with valid/ready result and sticky overflow / lost-product flags per vector.
module mac_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 16
) (
  input  logic       ck,
  input  logic       rst,
  mac_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [16:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_op_last;
  logic [TW-1:0]    r_tmr;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_timeout_err;
  logic             r_out_valid;
  logic             r_mul_start;
  logic [7:0]       r_mul_a;
  logic [7:0]       r_mul_b;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [16:0]      w_head;
  logic [ACC_W:0]   w_sum;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];
  // Extra top bit of the sum is the carry out of the ACC_W-bit add.
  assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(bus.mul_o);

  assign bus.in_ready    = !w_full;
  assign bus.out_valid   = r_out_valid;
  assign bus.acc_out     = r_acc;
  assign bus.ovf         = r_ovf;
  assign bus.timeout_err = r_timeout_err;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.mul_start   = r_mul_start;

  always_ff @(posedge ck) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_last, bus.in_a, bus.in_b};
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_op_last     <= 1'b0;
      r_tmr         <= '0;
      r_acc         <= '0;
      r_ovf         <= 1'b0;
      r_timeout_err <= 1'b0;
      r_out_valid   <= 1'b0;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          // Operands go straight to the multiplier regs so they are valid during LOAD.
          if (w_pop) begin
            r_op_last   <= w_head[16];
            r_mul_a     <= w_head[15:8];
            r_mul_b     <= w_head[7:0];
            r_mul_start <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mul_start <= 1'b0;
          r_tmr       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_tmr <= r_tmr + TW'(1);
          if (bus.mul_fin || (r_tmr == TMR_LAST)) begin
            if (bus.mul_fin) begin
              r_acc <= w_sum[ACC_W-1:0];
              if (w_sum[ACC_W]) r_ovf <= 1'b1;
            end else begin
              r_timeout_err <= 1'b1;
            end
            if (r_op_last) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
